// File: rtl/pc_pkg.sv
// Shared types and default widths for the program counter and its return stack.
package pc_pkg;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_JMP,
        CMD_CALL,
        CMD_RET
    } pc_cmd_t;

    localparam int PC_ADDR_W     = 4;
    localparam int PC_DEPTH      = 4;
    localparam int PC_RESET_ADDR = 0;

    // Fixed precedence: jmp > call > ret; losing commands are dropped, not queued.
    function automatic pc_cmd_t pc_encode(input logic jmp, input logic call, input logic ret);
        pc_cmd_t cmd;
        cmd = CMD_NONE;
        if (jmp) begin
            cmd = CMD_JMP;
        end else if (call) begin
            cmd = CMD_CALL;
        end else if (ret) begin
            cmd = CMD_RET;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Register-array LIFO holding return addresses; sp counts valid entries.
module pc_return_stack
    import pc_pkg::*;
#(
    parameter  int ADDR_W = PC_ADDR_W,
    parameter  int DEPTH  = PC_DEPTH,
    localparam int SP_W   = $clog2(DEPTH + 1),
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] top,
    output logic [SP_W-1:0]   sp,
    output logic              full,
    output logic              empty
);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [SP_W-1:0]   r_sp;

    logic              w_full;
    logic              w_empty;
    logic              w_do_push;
    logic              w_do_pop;
    logic [IDX_W-1:0]  w_push_idx;
    logic [IDX_W-1:0]  w_pop_idx;

    assign w_full  = (r_sp == SP_W'(DEPTH));
    assign w_empty = (r_sp == '0);

    // Push has precedence if both ever arrive together; the top level never does that.
    assign w_do_push = push && !w_full;
    assign w_do_pop  = pop && !w_empty && !push;

    // sp-1 is always below DEPTH, so the modular subtraction on the narrow index is exact.
    assign w_push_idx = r_sp[IDX_W-1:0];
    assign w_pop_idx  = w_push_idx - IDX_W'(1);

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_sp <= '0;
        end else if (w_do_push) begin
            r_sp <= r_sp + SP_W'(1);
        end else if (w_do_pop) begin
            r_sp <= r_sp - SP_W'(1);
        end
    end

    // Entries are deliberately left out of reset; anything at or above sp is don't-care.
    always_ff @(posedge CLK) begin
        if (w_do_push && !rst) begin
            r_mem[w_push_idx] <= din;
        end
    end

    assign top   = r_mem[w_pop_idx];
    assign sp    = r_sp;
    assign full  = w_full;
    assign empty = w_empty;

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with enable-gated increment, jump, and call/return through a return stack.
module pc_call_stack
    import pc_pkg::*;
#(
    parameter  int ADDR_W     = PC_ADDR_W,
    parameter  int DEPTH      = PC_DEPTH,
    parameter  int RESET_ADDR = PC_RESET_ADDR,
    localparam int SP_W       = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              enable,
    input  logic              jmp,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] jmploc,
    output logic [ADDR_W-1:0] count,
    output logic [SP_W-1:0]   sp,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              fault
);

    pc_cmd_t           w_cmd;
    logic              w_push;
    logic              w_pop;
    logic              w_overflow;
    logic              w_underflow;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W-1:0] w_top;
    logic [ADDR_W-1:0] w_count_inc;
    logic [ADDR_W-1:0] w_count_idle;
    logic [ADDR_W-1:0] w_count_next;
    logic [SP_W-1:0]   w_sp;

    logic [ADDR_W-1:0] r_count;
    logic              r_fault;

    assign w_cmd = pc_encode(jmp, call, ret);

    assign w_overflow  = (w_cmd == CMD_CALL) && w_full;
    assign w_underflow = (w_cmd == CMD_RET) && w_empty;

    assign w_push = !rst && (w_cmd == CMD_CALL) && !w_full;
    assign w_pop  = !rst && (w_cmd == CMD_RET) && !w_empty;

    assign w_count_inc  = r_count + ADDR_W'(1);
    assign w_count_idle = enable ? w_count_inc : r_count;

    // A rejected call/ret falls back to the plain increment/hold path.
    always_comb begin
        w_count_next = w_count_idle;
        case (w_cmd)
            CMD_JMP:  w_count_next = jmploc;
            CMD_CALL: w_count_next = w_full ? w_count_idle : jmploc;
            CMD_RET:  w_count_next = w_empty ? w_count_idle : w_top;
            default:  w_count_next = w_count_idle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_count <= ADDR_W'(RESET_ADDR);
            r_fault <= 1'b0;
        end else begin
            r_count <= w_count_next;
            if (w_overflow || w_underflow) begin
                r_fault <= 1'b1;
            end
        end
    end

    pc_return_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_stack (
        .CLK   (CLK),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_count_inc),
        .top   (w_top),
        .sp    (w_sp),
        .full  (w_full),
        .empty (w_empty)
    );

    assign count       = r_count;
    assign sp          = w_sp;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;
    assign fault       = r_fault;

endmodule

// File: doc/pc_call_stack.md
# pc_call_stack

Parametrised program counter for the microcomputer control path, adding a return-address stack for subroutine call/return. It generalises the 4-bit counter to any address width, gates increments with an enable, and supports jump, call and return. Output `count` drives the memory address register and instruction fetch.

## Interface
- `ADDR_W`, 4: width of `count`, `jmploc` and stack entries.
- `DEPTH`, 4: return-stack entries; must be ≥1.
- `RESET_ADDR`, 0: value loaded into `count` on reset.

- `CLK`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  increment enable; gates the increment only.
- `jmp`  in  1  load `jmploc` into `count`.
- `call`  in  1  push `count+1`, then load `jmploc`.
- `ret`  in  1  pop the stack top into `count`.
- `jmploc`  in  ADDR_W  target address for `jmp`/`call`.
- `count`  out  ADDR_W  current program address (registered).
- `sp`  out  $clog2(DEPTH+1)  number of valid stack entries (registered).
- `stack_full`  out  1  `sp == DEPTH` (combinational from `sp`).
- `stack_empty`  out  1  `sp == 0` (combinational from `sp`).
- `fault`  out  1  sticky flag for overflow/underflow (registered).

## Operation
- Priority each cycle: `rst` > `jmp` > `call` > `ret` > increment > hold. Lower-priority commands in the same cycle are ignored; they are not queued.
- `jmp`: `count <= jmploc`; the stack is unchanged; independent of `enable`.
- `call` with `sp < DEPTH`:
  - `stack[sp] <= count + 1` (mod 2^ADDR_W).
  - `sp <= sp + 1`.
  - `count <= jmploc`.
  - Independent of `enable`.
- `call` with `sp == DEPTH` (overflow):
  - `fault <= 1`.
  - Stack and `sp` are unchanged; no jump is taken.
  - `count` behaves as if no command was given (increments if `enable`, else holds).
- `ret` with `sp > 0`: `count <= stack[sp-1]`; `sp <= sp - 1`; independent of `enable`.
- `ret` with `sp == 0` (underflow): `fault <= 1`; `count` behaves as if no command was given.
- No command and `enable=1`: `count <= count + 1`. The counter wraps from 2^ADDR_W−1 to 0 with no flag.
- No command and `enable=0`: all state holds.
- `fault` is cleared only by `rst`.
- Stack entries are not cleared on reset; entries above `sp` are don't-care.

## Timing
- Reset values:
  - `count = RESET_ADDR`
  - `sp = 0`
  - `fault = 0`
  - `stack_empty = 1`, `stack_full = 0`
- `rst` asserted mid-sequence (e.g. with a pending `call`) wins outright: no push, no fault.
- Every command takes effect at the sampling edge, so the new `count`/`sp`/`fault` are visible one cycle later. There is no multi-cycle state and no busy condition.
- `jmploc` is sampled only on the edge where `jmp` or `call` wins arbitration.
- Back-to-back `call`, `call`, `ret`, `ret` on consecutive cycles are legal. The stack is a LIFO with no bypass hazard, because push and pop never occur in the same cycle.
- Single clock domain. The clock is never gated; `enable` is a data-path qualifier.

## Structure
- Shared package `pc_pkg`:
  - enum `pc_cmd_t` = {CMD_NONE, CMD_JMP, CMD_CALL, CMD_RET}, the result of the priority encode.
  - Default-width constants used by the instantiating datapath.
- Sub-module `pc_return_stack` (parameters `ADDR_W`, `DEPTH`):
  - Register-array LIFO.
  - Inputs: `push`, `pop`, `din`.
  - Outputs: `top`, `sp`, `full`, `empty`.
- Top level: priority encoder, overflow/underflow qualification, `count` and `fault` registers.

## Test plan
- Reset, then `enable=1` for 18 cycles with ADDR_W=4 → `count` runs 0,1,…,15,0,1; `fault=0`.
- At `count=3`, `jmp=1`, `jmploc=9`, `enable=0` → next cycle `count=9`, `sp=0`. Hold `enable=0` for 3 cycles → `count` stays 9.
- Nested calls:
  - At `count=2`, `call` to 8 → `count=8`, `sp=1`, `stack[0]=3`.
  - Then `call` to 12 → `count=12`, `sp=2`.
  - `ret` → `count=9`, `sp=1`.
  - `ret` → `count=3`, `sp=0`, `stack_empty=1`.
- With DEPTH=4, issue 5 consecutive calls with `enable=1` → after 4 calls `stack_full=1`. The 5th call sets `fault=1`, `sp` stays 4, and `count` increments instead of jumping.
- `ret` at `sp=0`, `enable=0` → `fault=1`, `count` unchanged. Assert `rst` → `fault=0`, `count=RESET_ADDR`.
- `jmp`, `call` and `ret` asserted together with `jmploc=5` → `count=5`, `sp` unchanged (`jmp` wins). Same cycle with `rst=1` → reset values only.
